dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported data memory. It lets the CPU load/store path (port 0) and a second master, such as a DMA engine or memory-mapped I/O bridge (port 1), share one `dmem` instance. The block latches one request at a time using round-robin priority and drives the memory's `mem_wr`/`mem_addr`/`mem_writedata` for exactly one cycle. It then returns registered read data, or a write acknowledge, to the winning requester.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 15 +
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// FSM state encoding and port index constants.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// On a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       winner
);

  assign any    = |req;
  assign winner = (&req) ? ~last : req[PORT_AUX];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one single-ported dmem between the CPU
// port and an auxiliary master; one access every ACCESS cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int Abits = 32,
  parameter int Dbits = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p0_req,
  input  logic             p0_wr,
  input  logic [Abits-1:0] p0_addr,
  input  logic [Dbits-1:0] p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [Dbits-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic             p1_wr,
  input  logic [Abits-1:0] p1_addr,
  input  logic [Dbits-1:0] p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [Dbits-1:0] p1_rdata,
  output logic             mem_wr,
  output logic [Abits-1:0] mem_addr,
  output logic [Dbits-1:0] mem_writedata,
  input  logic [Dbits-1:0] mem_readdata,
  output logic             busy
);

  arb_state_t       state;
  logic             cmd_wr;
  logic [Abits-1:0] cmd_addr;
  logic [Dbits-1:0] cmd_wdata;
  logic             cmd_port;
  logic             last;
  logic [Dbits-1:0] rsp;

  logic             any;
  logic             winner;
  logic             arb_last;
  logic             sel_wr;
  logic [Abits-1:0] sel_addr;
  logic [Dbits-1:0] sel_wdata;

  // In RESP the pointer update is still in flight, so use the
  // current winner directly to keep back-to-back ties fair.
  assign arb_last = (state == RESP) ? cmd_port : last;

  rr_arb2 u_rr (
    .req    ({p1_req, p0_req}),
    .last   (arb_last),
    .any    (any),
    .winner (winner)
  );

  assign sel_wr    = winner ? p1_wr    : p0_wr;
  assign sel_addr  = winner ? p1_addr  : p0_addr;
  assign sel_wdata = winner ? p1_wdata : p0_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_port  <= PORT_CPU;
      last      <= PORT_AUX;
      rsp       <= '0;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          if (state == RESP) begin
            last <= cmd_port;
          end
          if (any) begin
            cmd_wr    <= sel_wr;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_port  <= winner;
            state     <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (!cmd_wr) begin
            rsp <= mem_readdata;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_gnt    = (state == ACCESS) && (cmd_port == PORT_CPU);
  assign p1_gnt    = (state == ACCESS) && (cmd_port == PORT_AUX);
  assign p0_rvalid = (state == RESP) && (cmd_port == PORT_CPU);
  assign p1_rvalid = (state == RESP) && (cmd_port == PORT_AUX);
  assign p0_rdata  = rsp;
  assign p1_rdata  = rsp;

  // Reset gates the strobe combinationally so an in-flight write aborts.
  assign mem_wr        = (state == ACCESS) && cmd_wr && !reset;
  assign mem_addr      = cmd_addr;
  assign mem_writedata = cmd_wdata;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random
// two-port traffic against a reference memory and per-port FIFOs.
module tb_dmem_arbiter;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req   = '0;
  logic [1:0]        wr    = '0;
  logic [1:0][31:0]  addr_v  = '0;
  logic [1:0][31:0]  wdata_v = '0;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [1:0][31:0]  rdata_v;
  logic              mem_wr;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_lows = 0;

  logic [31:0] mem  [64];
  logic [31:0] refm [64];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur [2];
  logic [1:0] pend = '0;
  logic mon_en = 1'b0;

  dmem_arbiter #(.Abits(32), .Dbits(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .p0_req        (req[0]),
    .p0_wr         (wr[0]),
    .p0_addr       (addr_v[0]),
    .p0_wdata      (wdata_v[0]),
    .p0_gnt        (gnt[0]),
    .p0_rvalid     (rvalid[0]),
    .p0_rdata      (rdata_v[0]),
    .p1_req        (req[1]),
    .p1_wr         (wr[1]),
    .p1_addr       (addr_v[1]),
    .p1_wdata      (wdata_v[1]),
    .p1_gnt        (gnt[1]),
    .p1_rvalid     (rvalid[1]),
    .p1_rdata      (rdata_v[1]),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Memory model standing in for dmem
  assign mem_readdata = mem[mem_addr[5:0]];
  always @(posedge clock) begin
    if (mem_wr) mem[mem_addr[5:0]] <= mem_writedata;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pop expectation on gnt, check response one cycle later
  always @(negedge clock) begin
    if (!busy) busy_lows++;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] || rvalid[i])
          check($sformatf("p%0d_rvalid_timing", i),
                32'(rvalid[i]), 32'(pend[i]));
        if (rvalid[i] && pend[i] && !cur[i].wr)
          check($sformatf("p%0d_rdata", i), rdata_v[i], cur[i].rdata);
        if (gnt[i]) begin
          check($sformatf("p%0d_gnt_rvalid_overlap", i),
                32'(rvalid[i]), 32'd0);
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL p%0d_unexpected_gnt: got 1 expected 0", i);
          end else begin
            if (i == 0) cur[0] = q0.pop_front();
            else        cur[1] = q1.pop_front();
            check($sformatf("p%0d_mem_addr", i), mem_addr, cur[i].addr);
            check($sformatf("p%0d_mem_wr", i), 32'(mem_wr), 32'(cur[i].wr));
            if (cur[i].wr)
              check($sformatf("p%0d_mem_wdata", i), mem_writedata,
                    cur[i].wdata);
          end
        end
      end
      check("gnt_both", 32'(&gnt), 32'd0);
      pend = gnt;
    end else begin
      pend = '0;
    end
  end

  // Issue one command on port p; returns in the RESP cycle with req low
  task automatic drive(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int waited);
    exp_t e;
    e.wr    = w;
    e.addr  = a;
    e.wdata = d;
    e.rdata = refm[a[5:0]];
    if (w) refm[a[5:0]] = d;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
    wr[p]      = w;
    addr_v[p]  = a;
    wdata_v[p] = d;
    req[p]     = 1'b1;
    waited = 0;
    do begin
      @(posedge clock);
      #1;
      waited++;
    end while (!gnt[p] && waited < 20);
    if (!gnt[p]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL p%0d_gnt_timeout: got none expected gnt", p);
      req[p] = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, w0, w1, bl;
    logic [31:0] a_hold;
    for (int i = 0; i < 64; i++) begin
      mem[i]  = $urandom;
      refm[i] = mem[i];
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ctrl", 32'({gnt, rvalid, busy, mem_wr}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_writedata, 32'd0);
    check("rst_p0_rdata", rdata_v[0], 32'd0);
    check("rst_p1_rdata", rdata_v[1], 32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single write then read
    drive(0, 1'b1, 32'h8, 32'hDEADBEEF, w);
    check("t1_write_gnt_lat", 32'(w), 32'd1);
    drive(0, 1'b0, 32'h8, 32'h0, w);
    check("t1_read_gnt_lat", 32'(w), 32'd1);
    check("t1_rdata", rdata_v[0], 32'hDEADBEEF);

    // Simultaneous requests after reset, then a second tie
    do_reset();
    fork
      drive(0, 1'b0, 32'h4, 32'h0, w0);
      drive(1, 1'b0, 32'h10, 32'h0, w1);
    join
    check("t2_p0_gnt_cycle", 32'(w0), 32'd1);
    check("t2_p1_gnt_cycle", 32'(w1), 32'd3);
    fork
      drive(0, 1'b0, 32'h5, 32'h0, w0);
      drive(1, 1'b0, 32'h11, 32'h0, w1);
    join
    check("t2_tie2_p0", 32'(w0), 32'd1);
    check("t2_tie2_p1", 32'(w1), 32'd3);

    // Back-to-back on port 1
    bl = busy_lows;
    drive(1, 1'b1, 32'h14, 32'hA5A5_0001, w);
    drive(1, 1'b1, 32'h15, 32'hA5A5_0002, w);
    check("t3_gnt_gap", 32'(w), 32'd1);
    check("t3_busy_held", 32'(busy_lows - bl), 32'd0);

    // Reset during the ACCESS cycle of a write
    @(posedge clock);
    #1;
    mon_en     = 1'b0;
    wr[0]      = 1'b1;
    addr_v[0]  = 32'hC;
    wdata_v[0] = 32'h12345678;
    req[0]     = 1'b1;
    @(posedge clock);
    #1;
    check("t4_in_access", 32'(gnt[0]), 32'd1);
    reset  = 1'b1;
    req[0] = 1'b0;
    #1;
    check("t4_mem_wr_gated", 32'(mem_wr), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("t4_ctrl", 32'({gnt, rvalid, busy, mem_wr}), 32'd0);
    check("t4_mem_addr", mem_addr, 32'd0);
    check("t4_mem_wdata", mem_writedata, 32'd0);
    check("t4_rdata", rdata_v[0], 32'd0);
    mon_en = 1'b1;
    @(posedge clock);
    #1;
    drive(0, 1'b0, 32'hC, 32'h0, w);
    check("t4_readback", rdata_v[0], refm[12]);

    // Port 0 saturating, port 1 raises one read
    fork
      begin
        for (int k = 0; k < 8; k++)
          drive(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)),
                $urandom, w0);
      end
      begin
        repeat (3) @(posedge clock);
        #1;
        drive(1, 1'b0, 32'd40, 32'h0, w1);
        check("t5_p1_wait", 32'(w1 <= 4), 32'd1);
      end
    join

    // Idle window
    @(posedge clock);
    #1;
    a_hold = mem_addr;
    repeat (10) begin
      @(negedge clock);
      check("t6_idle", 32'({mem_wr, gnt, rvalid, busy}), 32'd0);
    end
    check("t6_addr_hold", mem_addr, a_hold);

    // Random traffic on disjoint address halves
    @(posedge clock);
    #1;
    fork
      begin
        int wa;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
          drive(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)),
                $urandom, wa);
          check("rand_p0_wait", 32'(wa <= 4), 32'd1);
        end
      end
      begin
        int wb;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
          drive(1, 1'($urandom_range(0, 1)), 32'($urandom_range(32, 63)),
                $urandom, wb);
          check("rand_p1_wait", 32'(wb <= 4), 32'd1);
        end
      end
    join

    repeat (3) @(negedge clock);
    check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
